render_cmd_queue: RTL and testbench

Double-banked render command scheduler between the Avalon slave (software) and `vga_display`. Software assembles 48-bit sprite commands from 16-bit writes into a fill bank, then commits. At the next end-of-field the committed bank becomes active. `vga_display` pops the active commands each frame and sees the `DO_RENDER` sentinel once the list is exhausted. The active list replays every frame until a new commit swaps it out.

---
 rtl/vga_pkg.sv | 59 +++++
 rtl/cmd_bank.sv | 35 +++
 rtl/render_cmd_queue.sv | 224 ++++++++++++++++++++++
 tb/tb_render_cmd_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA render command path.
package vga_pkg;

  // Entries per render bank as seen by vga_display.
  localparam int VGA_RENDER_Q_LEN = 25;

  // Magic byte that tells vga_display the command list is exhausted.
  localparam logic [7:0] VGA_DO_RENDER = 8'hFF;

  // Sprite kinds carried in the magic byte of a render command.
  localparam logic [7:0] SPRITE_MAGIC_NONE   = 8'h00;
  localparam logic [7:0] SPRITE_MAGIC_PLAYER = 8'h01;
  localparam logic [7:0] SPRITE_MAGIC_ENEMY  = 8'h02;
  localparam logic [7:0] SPRITE_MAGIC_BULLET = 8'h03;
  localparam logic [7:0] SPRITE_MAGIC_TEXT   = 8'h04;

  typedef struct packed {
    logic [7:0]  magic;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  flags;
  } render_cmd_t;

  localparam render_cmd_t SENTINEL_CMD = '{
    magic: VGA_DO_RENDER,
    x:     16'h0000,
    y:     16'h0000,
    flags: 8'h00
  };

  // Avalon register map. Status readback shares index 0 with the
  // {magic, flags} staging write.
  localparam logic [2:0] REG_MAGIC_FLAGS = 3'd0;
  localparam logic [2:0] REG_X           = 3'd1;
  localparam logic [2:0] REG_Y           = 3'd2;
  localparam logic [2:0] REG_PUSH        = 3'd3;
  localparam logic [2:0] REG_COMMIT      = 3'd4;
  localparam logic [2:0] REG_CLEAR       = 3'd5;
  localparam logic [2:0] REG_STATUS      = 3'd0;

  // Bank swap state: either filling freely, or holding a committed fill
  // bank until the next end of field.
  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // Status word layout seen by software.
  function automatic logic [15:0] pack_status(
    input logic [4:0] fill_count,
    input logic [4:0] active_count,
    input logic       rejected,
    input logic       overflow,
    input logic       pending
  );
    return {pending, overflow, rejected, 3'b000, active_count, fill_count};
  endfunction

endpackage

// File: rtl/cmd_bank.sv
// One bank of render commands: synchronous write, combinational read.
module cmd_bank
  import vga_pkg::*;
#(
  parameter int DEPTH  = VGA_RENDER_Q_LEN,
  parameter int ADDR_W = 5
) (
  input  logic              clk50,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  render_cmd_t       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output render_cmd_t       rdata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  render_cmd_t mem [DEPTH];

  // Store a command; addresses past the last entry are dropped.
  always_ff @(posedge clk50) begin
    if (we && (waddr <= LAST)) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read; out-of-range reads return the sentinel.
  always_comb begin
    rdata = SENTINEL_CMD;
    if (raddr <= LAST) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/render_cmd_queue.sv
// Double-banked render command scheduler between software and vga_display.
//
// state        | meaning
// -------------+---------------------------------------------------------
// SWAP_IDLE    | fill bank open for pushes; active bank replays each frame
// SWAP_PENDING | fill bank committed and frozen, swaps at next end_of_field
module render_cmd_queue
  import vga_pkg::*;
#(
  parameter int DEPTH = VGA_RENDER_Q_LEN,
  parameter int CNT_W = 5
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        end_of_field,
  output logic [47:0] render_queue_dout,
  input  logic        render_queue_pop_front
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  swap_state_t state;
  swap_state_t state_nxt;

  logic [7:0]       stg_magic;
  logic [7:0]       stg_flags;
  logic [15:0]      stg_x;
  logic [15:0]      stg_y;

  logic [CNT_W-1:0] fill_count;
  logic [CNT_W-1:0] active_count;
  logic [CNT_W-1:0] rd_ptr;
  logic             fill_sel;
  logic             overflow;
  logic             rejected;
  logic             pending;

  logic             wr_en;
  logic             rd_en;
  logic             do_push;
  logic             do_commit;
  logic             do_clear;

  logic             push_ok;
  logic             set_overflow;
  logic             set_rejected;
  logic             swap;
  logic             clear_fill;

  render_cmd_t      stage_cmd;
  render_cmd_t      bank0_rdata;
  render_cmd_t      bank1_rdata;
  render_cmd_t      active_rdata;

  assign wr_en     = chipselect && write;
  assign rd_en     = chipselect && read;
  assign do_push   = wr_en && (address == REG_PUSH);
  assign do_commit = wr_en && (address == REG_COMMIT);
  assign do_clear  = wr_en && (address == REG_CLEAR);
  assign pending   = (state == SWAP_PENDING);

  assign stage_cmd = '{magic: stg_magic, x: stg_x, y: stg_y, flags: stg_flags};

  // Swap state register.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state <= SWAP_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle bank control decode.
  always_comb begin
    state_nxt    = state;
    push_ok      = 1'b0;
    set_overflow = 1'b0;
    set_rejected = 1'b0;
    swap         = 1'b0;
    clear_fill   = 1'b0;
    case (state)
      SWAP_IDLE: begin
        if (do_clear) begin
          clear_fill = 1'b1;
        end else if (do_commit) begin
          state_nxt = SWAP_PENDING;
        end else if (do_push) begin
          if (fill_count < DEPTH_C) begin
            push_ok = 1'b1;
          end else begin
            set_overflow = 1'b1;
          end
        end
      end
      SWAP_PENDING: begin
        // The committed bank is frozen; a push here is lost.
        if (do_push) begin
          set_rejected = 1'b1;
        end
        // Clear beats a coincident end_of_field so the swap is cancelled.
        if (do_clear) begin
          clear_fill = 1'b1;
          state_nxt  = SWAP_IDLE;
        end else if (end_of_field) begin
          swap      = 1'b1;
          state_nxt = SWAP_IDLE;
        end
      end
      default: state_nxt = SWAP_IDLE;
    endcase
  end

  // Staging registers; they keep their value across pushes.
  always_ff @(posedge clk50) begin
    if (reset) begin
      stg_magic <= 8'h00;
      stg_flags <= 8'h00;
      stg_x     <= 16'h0000;
      stg_y     <= 16'h0000;
    end else if (wr_en) begin
      case (address)
        REG_MAGIC_FLAGS: begin
          stg_magic <= writedata[15:8];
          stg_flags <= writedata[7:0];
        end
        REG_X:   stg_x <= writedata;
        REG_Y:   stg_y <= writedata;
        default: ;
      endcase
    end
  end

  // Fill/active counts and bank ownership.
  always_ff @(posedge clk50) begin
    if (reset) begin
      fill_count   <= '0;
      active_count <= '0;
      fill_sel     <= 1'b0;
    end else begin
      if (clear_fill || swap) begin
        fill_count <= '0;
      end else if (push_ok) begin
        fill_count <= fill_count + CNT_W'(1);
      end
      if (swap) begin
        active_count <= fill_count;
        fill_sel     <= ~fill_sel;
      end
    end
  end

  // Sticky error flags, cleared only by software clear.
  always_ff @(posedge clk50) begin
    if (reset) begin
      overflow <= 1'b0;
      rejected <= 1'b0;
    end else if (clear_fill) begin
      overflow <= 1'b0;
      rejected <= 1'b0;
    end else begin
      if (set_overflow) overflow <= 1'b1;
      if (set_rejected) rejected <= 1'b1;
    end
  end

  // Read pointer: rewinds every field, pops saturate at the sentinel.
  always_ff @(posedge clk50) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (end_of_field) begin
      rd_ptr <= '0;
    end else if (render_queue_pop_front && (rd_ptr < active_count)) begin
      rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // Registered status readback.
  always_ff @(posedge clk50) begin
    if (reset) begin
      readdata <= 16'h0000;
    end else if (rd_en) begin
      if (address == REG_STATUS) begin
        readdata <= pack_status(fill_count, active_count, rejected, overflow, pending);
      end else begin
        readdata <= 16'h0000;
      end
    end
  end

  cmd_bank #(
    .DEPTH  (DEPTH),
    .ADDR_W (CNT_W)
  ) u_bank0 (
    .clk50 (clk50),
    .we    (push_ok && !fill_sel),
    .waddr (fill_count),
    .wdata (stage_cmd),
    .raddr (rd_ptr),
    .rdata (bank0_rdata)
  );

  cmd_bank #(
    .DEPTH  (DEPTH),
    .ADDR_W (CNT_W)
  ) u_bank1 (
    .clk50 (clk50),
    .we    (push_ok && fill_sel),
    .waddr (fill_count),
    .wdata (stage_cmd),
    .raddr (rd_ptr),
    .rdata (bank1_rdata)
  );

  // The active bank is whichever one is not being filled.
  assign active_rdata      = fill_sel ? bank0_rdata : bank1_rdata;
  assign render_queue_dout = (rd_ptr < active_count) ? active_rdata : SENTINEL_CMD;

endmodule

// File: tb/tb_render_cmd_queue.sv
// Scoreboard bench for render_cmd_queue with a list-based reference model.
module tb_render_cmd_queue;

  localparam logic [47:0] SENT = 48'hFF00_0000_0000;
  localparam int          QLEN = 25;

  logic        clk50 = 1'b0;
  logic        reset = 1'b0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [2:0]  address = 3'd0;
  logic [15:0] writedata = 16'h0;
  logic [15:0] readdata;
  logic        end_of_field = 1'b0;
  logic [47:0] render_queue_dout;
  logic        render_queue_pop_front = 1'b0;
  logic        obs = 1'b0;

  render_cmd_queue dut (
    .clk50                  (clk50),
    .reset                  (reset),
    .chipselect             (chipselect),
    .write                  (write),
    .read                   (read),
    .address                (address),
    .writedata              (writedata),
    .readdata               (readdata),
    .end_of_field           (end_of_field),
    .render_queue_dout      (render_queue_dout),
    .render_queue_pop_front (render_queue_pop_front)
  );

  always #10 clk50 = ~clk50;

  int n_vec = 0;
  int n_err = 0;

  logic [47:0] q_dout[$];
  logic [15:0] q_rd[$];
  bit          rd_prev = 1'b0;

  // Reference model: two plain command lists plus flags.
  logic [47:0] m_fill[$];
  logic [47:0] m_active[$];
  int          m_rd = 0;
  bit          m_pend = 0, m_ovf = 0, m_rej = 0;
  logic [7:0]  m_magic = 0, m_flags = 0;
  logic [15:0] m_x = 0, m_y = 0;

  function automatic logic [47:0] m_dout();
    if (m_rd < m_active.size()) return m_active[m_rd];
    return SENT;
  endfunction

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = 16'h0;
    s[4:0]  = 5'(m_fill.size());
    s[9:5]  = 5'(m_active.size());
    s[13]   = m_rej;
    s[14]   = m_ovf;
    s[15]   = m_pend;
    return s;
  endfunction

  // One clock cycle: drive inputs, queue expectations, advance the model.
  task automatic cyc(input bit wr, input logic [2:0] a, input logic [15:0] d,
                     input bit rd, input bit eof, input bit pp, input bit ob, input bit rst);
    bit was_pend;
    reset = rst;
    chipselect = wr | rd;
    write = wr;
    read = rd;
    address = a;
    writedata = d;
    end_of_field = eof;
    render_queue_pop_front = pp;
    obs = ob;
    if (!rst && (pp || ob)) q_dout.push_back(m_dout());
    if (!rst && rd) q_rd.push_back((a == 3'd0) ? m_status() : 16'h0);
    if (rst) begin
      m_fill.delete(); m_active.delete();
      m_rd = 0; m_pend = 0; m_ovf = 0; m_rej = 0;
      m_magic = 0; m_flags = 0; m_x = 0; m_y = 0;
    end else begin
      was_pend = m_pend;
      if (wr) begin
        case (a)
          3'd0: begin m_magic = d[15:8]; m_flags = d[7:0]; end
          3'd1: m_x = d;
          3'd2: m_y = d;
          3'd3: begin
            if (m_pend) m_rej = 1;
            else if (m_fill.size() < QLEN) m_fill.push_back({m_magic, m_x, m_y, m_flags});
            else m_ovf = 1;
          end
          3'd4: m_pend = 1;
          3'd5: begin m_fill.delete(); m_ovf = 0; m_rej = 0; m_pend = 0; end
          default: ;
        endcase
      end
      if (eof) begin
        if (was_pend && !(wr && a == 3'd5)) begin
          m_active = m_fill;
          m_fill.delete();
          m_pend = 0;
        end
        m_rd = 0;
      end else if (pp && m_rd < m_active.size()) begin
        m_rd++;
      end
    end
    @(posedge clk50);
    #1;
    reset = 0; chipselect = 0; write = 0; read = 0;
    end_of_field = 0; render_queue_pop_front = 0; obs = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cyc(1, a, d, 0, 0, 0, 1, 0);
  endtask
  task automatic rd(input logic [2:0] a);
    cyc(0, a, 16'h0, 1, 0, 0, 1, 0);
  endtask
  task automatic tick(input bit eof, input bit pp, input bit ob);
    cyc(0, 3'd0, 16'h0, 0, eof, pp, ob, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    forever begin
      @(negedge clk50);
      if (rd_prev) begin
        n_vec++;
        if (q_rd.size() == 0) begin
          n_err++;
          $display("FAIL readdata: got %h, no expected value queued", readdata);
        end else begin
          logic [15:0] e;
          e = q_rd.pop_front();
          if (readdata !== e) begin
            n_err++;
            $display("FAIL readdata: got %h expected %h at %0t", readdata, e, $time);
          end
        end
      end
      rd_prev = chipselect && read;
      if (render_queue_pop_front || obs) begin
        n_vec++;
        if (q_dout.size() == 0) begin
          n_err++;
          $display("FAIL dout: got %h, no expected value queued", render_queue_dout);
        end else begin
          logic [47:0] e;
          e = q_dout.pop_front();
          if (render_queue_dout !== e) begin
            n_err++;
            $display("FAIL dout: got %h expected %h at %0t", render_queue_dout, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got t=%0t required < 1000000", $time);
    $fatal(1);
  end

  initial begin
    // Reset, then two quiet frames showing only the sentinel.
    cyc(0, 3'd0, 16'h0, 0, 0, 0, 0, 1);
    cyc(0, 3'd0, 16'h0, 0, 0, 0, 0, 1);
    tick(0, 0, 1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) tick(0, 0, 1);
      tick(1, 0, 1);
    end
    rd(3'd0);
    rd(3'd5);

    // Two commands differing only in x, commit, swap, pop and replay.
    wr(3'd0, {8'h01, 8'h01});
    wr(3'd1, 16'd320);
    wr(3'd2, 16'd240);
    wr(3'd3, 16'h0);
    wr(3'd1, 16'd100);
    wr(3'd3, 16'h0);
    rd(3'd0);
    wr(3'd4, 16'h0);
    rd(3'd0);
    tick(1, 0, 1);
    tick(0, 0, 1);
    tick(0, 1, 1);
    tick(0, 1, 1);
    tick(0, 1, 1);
    tick(0, 0, 1);
    tick(1, 0, 1);
    tick(0, 1, 1);
    tick(0, 1, 1);
    tick(0, 0, 1);
    rd(3'd0);

    // Overfill: 26 pushes, the last one dropped.
    for (int i = 0; i < 26; i++) begin
      wr(3'd1, 16'(i + 1000));
      wr(3'd3, 16'h0);
    end
    rd(3'd0);

    // Commit, then push while pending; swap on the next field.
    wr(3'd4, 16'h0);
    wr(3'd3, 16'h0);
    rd(3'd0);
    tick(1, 0, 1);
    rd(3'd0);
    for (int i = 0; i < 24; i++) tick(0, 1, 1);
    tick(0, 0, 1);
    tick(0, 1, 1);
    tick(0, 1, 1);

    // Pop and end_of_field together at rd_ptr=1.
    tick(1, 0, 1);
    tick(0, 1, 1);
    tick(1, 1, 1);
    tick(0, 0, 1);

    // Commit, then clear together with end_of_field: no swap.
    wr(3'd1, 16'd7);
    wr(3'd3, 16'h0);
    wr(3'd4, 16'h0);
    cyc(1, 3'd5, 16'h0, 0, 1, 0, 1, 0);
    rd(3'd0);
    tick(0, 1, 1);
    tick(0, 1, 1);
    tick(0, 0, 1);

    // Reset mid-frame returns to the sentinel immediately.
    cyc(0, 3'd0, 16'h0, 0, 0, 0, 0, 1);
    tick(0, 1, 1);
    rd(3'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit eof, pp, ob;
      r   = $urandom_range(0, 99);
      eof = ($urandom_range(0, 39) == 0);
      pp  = ($urandom_range(0, 2) == 0);
      ob  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) begin
        cyc(0, 3'd0, 16'h0, 0, 0, 0, 0, 1);
      end else if (r < 8) begin
        cyc(1, 3'd0, 16'($urandom), 0, eof, pp, ob, 0);
      end else if (r < 14) begin
        cyc(1, 3'd1, 16'($urandom), 0, eof, pp, ob, 0);
      end else if (r < 20) begin
        cyc(1, 3'd2, 16'($urandom), 0, eof, pp, ob, 0);
      end else if (r < 45) begin
        cyc(1, 3'd3, 16'($urandom), 0, eof, pp, ob, 0);
      end else if (r < 50) begin
        cyc(1, 3'd4, 16'($urandom), 0, eof, pp, ob, 0);
      end else if (r < 52) begin
        cyc(1, 3'd5, 16'($urandom), 0, eof, pp, ob, 0);
      end else if (r < 54) begin
        cyc(1, 3'($urandom_range(6, 7)), 16'($urandom), 0, eof, pp, ob, 0);
      end else if (r < 64) begin
        cyc(0, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
            16'h0, 1, eof, pp, ob, 0);
      end else begin
        cyc(0, 3'd0, 16'h0, 0, eof, pp, ob, 0);
      end
    end

    tick(0, 0, 0);
    tick(0, 0, 0);
    n_vec++;
    if (q_dout.size() != 0 || q_rd.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d dout and %0d read entries left, required 0 and 0",
               q_dout.size(), q_rd.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
